// File: rtl/mmio_uart_tx_pkg.sv
// Shared types and register-map constants for the memory-mapped UART transmitter.
package uart_pkg;

    // Transmit FSM states: one start bit, eight data bits, one stop bit.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // Byte offsets from BASE_ADDR.
    localparam logic [31:0] TXDATA_OFF = 32'd0;
    localparam logic [31:0] STATUS_OFF = 32'd4;

    // Status word bit positions.
    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_BUSY    = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 4;

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Single-clock FIFO with first-word fall-through output. A push into a full
// FIFO is accepted when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             push_ok, pop_ok;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign dout    = mem[rd_ptr_q];

    // Occupancy update; simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage array, written only on an accepted push.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= din;
        end
    end

    // Pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: snoops core stores, queues bytes and
// serialises them on tx with a registered output.
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h3020,
    parameter int          CLK_DIV    = 434,
    parameter int          FIFO_DEPTH = 8,
    parameter int          FIFO_AW    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] m_addr,
    input  logic [31:0] m_data,
    input  logic        wea,
    output logic [31:0] rdata,
    output logic        tx,
    output logic        busy,
    output logic        full
);

    localparam logic [15:0] BAUD_RELOAD = 16'(CLK_DIV - 1);

    tx_state_t        state_q;
    logic [15:0]      baud_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic             tx_q;
    logic             overflow_q;

    logic             wr_txdata, wr_ctrl;
    logic             fifo_pop, fifo_full, fifo_empty;
    logic [7:0]       fifo_dout;
    logic [FIFO_AW:0] fifo_count;
    logic [31:0]      status;
    logic             unused_data;

    assign wr_txdata   = wea && (m_addr == BASE_ADDR + TXDATA_OFF);
    assign wr_ctrl     = wea && (m_addr == BASE_ADDR + STATUS_OFF);
    assign unused_data = ^m_data[31:8];

    // A new byte is taken from the FIFO when idle, or at the end of a stop
    // bit so back-to-back frames have no gap.
    assign fifo_pop = !fifo_empty &&
                      ((state_q == IDLE) || (state_q == STOP && baud_q == '0));

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_txdata),
        .pop   (fifo_pop),
        .din   (m_data[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Frame sequencer: baud counter, bit index, shift register and tx line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (fifo_pop) begin
                        shift_q <= fifo_dout;
                        baud_q  <= BAUD_RELOAD;
                        state_q <= START;
                        tx_q    <= 1'b0;
                    end
                end
                START: begin
                    if (baud_q == '0) begin
                        baud_q    <= BAUD_RELOAD;
                        bit_idx_q <= '0;
                        state_q   <= DATA;
                        tx_q      <= shift_q[0];
                    end else begin
                        baud_q <= baud_q - 1'b1;
                    end
                end
                DATA: begin
                    if (baud_q == '0) begin
                        baud_q <= BAUD_RELOAD;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                            shift_q   <= shift_q >> 1;
                            tx_q      <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q - 1'b1;
                    end
                end
                STOP: begin
                    if (baud_q == '0) begin
                        if (fifo_pop) begin
                            shift_q <= fifo_dout;
                            baud_q  <= BAUD_RELOAD;
                            state_q <= START;
                            tx_q    <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                            tx_q    <= 1'b1;
                        end
                    end else begin
                        baud_q <= baud_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    // Sticky overflow: set on a dropped byte, cleared by writing bit0 of CTRL.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_q <= 1'b0;
        end else if (wr_ctrl && m_data[0]) begin
            overflow_q <= 1'b0;
        end else if (wr_txdata && fifo_full && !fifo_pop) begin
            overflow_q <= 1'b1;
        end
    end

    // Status word assembly and read mux.
    always_comb begin
        status                               = '0;
        status[ST_FULL]                      = fifo_full;
        status[ST_EMPTY]                     = fifo_empty;
        status[ST_BUSY]                      = (state_q != IDLE);
        status[ST_OVF]                       = overflow_q;
        status[ST_CNT_LSB +: FIFO_AW + 1]    = fifo_count;
        rdata = (m_addr == BASE_ADDR + STATUS_OFF) ? status : 32'd0;
    end

    assign tx   = tx_q;
    assign busy = (state_q != IDLE);
    assign full = fifo_full;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx with CLK_DIV=4: frame timing, back-to-back
// frames, overflow handling, ignored addresses and mid-frame reset.
module tb_mmio_uart_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_data = '0;
    logic        wea = 1'b0;
    logic [31:0] rdata;
    logic        tx, busy, full;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int n      = 0;

    logic tx_log   [4096];
    logic busy_log [4096];

    localparam logic [31:0] TXD = 32'h3020;
    localparam logic [31:0] STA = 32'h3024;

    mmio_uart_tx #(.CLK_DIV(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .m_addr (m_addr),
        .m_data (m_data),
        .wea    (wea),
        .rdata  (rdata),
        .tx     (tx),
        .busy   (busy),
        .full   (full)
    );

    always #5 clk = ~clk;

    // Edge counter and per-edge record of tx/busy, sampled mid-cycle.
    always @(posedge clk) cyc = cyc + 1;
    always @(negedge clk) begin
        tx_log[cyc % 4096]   = tx;
        busy_log[cyc % 4096] = busy;
    end

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        we;
        logic [31:0] exp_rd_now;
        logic [31:0] exp_status;
        logic        exp_tx;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic w);
        m_addr = a;
        m_data = d;
        wea    = w;
        if (w) $display("bus write addr=%h data=%h at edge %0d", a, d, cyc + 1);
    endtask

    // Compares one 40-cycle frame starting at edge s, one check per bit slot.
    task automatic check_frame(input int s, input logic [7:0] b, input string nm);
        logic [3:0] got;
        logic       e;
        for (int bi = 0; bi < 10; bi++) begin
            e = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : b[bi-1];
            for (int j = 0; j < 4; j++) got[j] = tx_log[(s + 4*bi + j) % 4096];
            chk($sformatf("%s bit%0d", nm, bi), {28'd0, got}, {28'd0, {4{e}}});
        end
        $display("frame %s byte=%h checked from edge %0d", nm, b, s);
    endtask

    task automatic wait_edge(input int target, input string nm);
        for (int k = 0; k < 2000 && cyc != target; k++) @(negedge clk);
        chk({nm, " reach edge"}, cyc, target);
    endtask

    vec_t vecs [5];
    int   busy_cnt;
    bit   idle_seen;

    initial begin
        vecs[0] = '{32'h3000, 32'h11, 1'b1, 32'h0, 32'h2, 1'b1};
        vecs[1] = '{32'h301C, 32'h22, 1'b1, 32'h0, 32'h2, 1'b1};
        vecs[2] = '{32'h3028, 32'h33, 1'b1, 32'h0, 32'h2, 1'b1};
        vecs[3] = '{STA,      32'h01, 1'b1, 32'h2, 32'h2, 1'b1};
        vecs[4] = '{32'h3028, 32'h00, 1'b0, 32'h0, 32'h2, 1'b1};

        // Reset state
        bus(STA, 0, 0);
        repeat (3) @(negedge clk);
        #1;
        chk("reset tx", {31'd0, tx}, 32'd1);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset full", {31'd0, full}, 32'd0);
        chk("reset status", rdata, 32'h2);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Single frame 0x55
        bus(TXD, 32'h55, 1);
        @(negedge clk);
        n = cyc;
        bus(32'h0, 0, 0);
        repeat (44) @(negedge clk);
        check_frame(n + 1, 8'h55, "f55");
        busy_cnt = 0;
        for (int k = 1; k <= 40; k++) busy_cnt += busy_log[(n + k) % 4096];
        chk("f55 busy cycles", busy_cnt, 40);
        chk("f55 busy before", {31'd0, busy_log[n % 4096]}, 32'd0);
        chk("f55 busy after", {31'd0, busy_log[(n + 41) % 4096]}, 32'd0);

        // Back-to-back frames 0xA5, 0x0F
        bus(TXD, 32'hA5, 1);
        @(negedge clk);
        n = cyc;
        bus(TXD, 32'h0F, 1);
        @(negedge clk);
        bus(32'h0, 0, 0);
        repeat (85) @(negedge clk);
        check_frame(n + 1, 8'hA5, "fA5");
        check_frame(n + 41, 8'h0F, "f0F");
        chk("b2b idle after", {31'd0, busy_log[(n + 81) % 4096]}, 32'd0);

        // Ten writes: nine accepted, tenth dropped
        for (int i = 0; i < 10; i++) begin
            bus(TXD, 32'h10 + i, 1);
            @(negedge clk);
            if (i == 0) n = cyc;
        end
        bus(STA, 0, 0);
        #1;
        chk("ovf status", rdata, 32'h8D);
        chk("ovf full pin", {31'd0, full}, 32'd1);
        bus(STA, 32'h1, 1);
        @(negedge clk);
        bus(STA, 0, 0);
        #1;
        chk("ovf clear status", rdata, 32'h85);

        // Write into full FIFO in the STOP->START pop cycle
        wait_edge(n + 40, "pop cycle");
        bus(TXD, 32'h77, 1);
        @(negedge clk);
        bus(STA, 0, 0);
        #1;
        chk("pop+push status", rdata, 32'h85);
        chk("pop+push tx start", {31'd0, tx}, 32'd0);
        bus(32'h0, 0, 0);
        idle_seen = 1'b0;
        for (int k = 0; k < 1000 && !idle_seen; k++) begin
            @(negedge clk);
            if (!busy) idle_seen = 1'b1;
        end
        chk("drain finished", {31'd0, idle_seen}, 32'd1);
        chk("drain end edge", cyc, n + 401);
        check_frame(n + 1, 8'h10, "q0");
        check_frame(n + 41, 8'h11, "q1");
        check_frame(n + 361, 8'h77, "q9");
        bus(STA, 0, 0);
        #1;
        chk("drained status", rdata, 32'h2);

        // Ignored addresses and reads, table-driven
        for (int v = 0; v < 5; v++) begin
            bus(vecs[v].addr, vecs[v].data, vecs[v].we);
            #1;
            chk($sformatf("vec%0d rdata", v), rdata, vecs[v].exp_rd_now);
            @(negedge clk);
            bus(STA, 0, 0);
            #1;
            chk($sformatf("vec%0d status", v), rdata, vecs[v].exp_status);
            chk($sformatf("vec%0d tx", v), {31'd0, tx}, {31'd0, vecs[v].exp_tx});
            $display("vector %0d addr=%h we=%0d status=%h", v, vecs[v].addr, vecs[v].we, rdata);
        end

        // Reset during data bit 3
        bus(TXD, 32'h00, 1);
        @(negedge clk);
        n = cyc;
        bus(TXD, 32'h33, 1);
        @(negedge clk);
        bus(STA, 0, 0);
        wait_edge(n + 18, "data bit3");
        chk("pre-reset tx low", {31'd0, tx}, 32'd0);
        rst = 1'b0;
        #1;
        chk("async reset tx", {31'd0, tx}, 32'd1);
        chk("async reset busy", {31'd0, busy}, 32'd0);
        chk("async reset status", rdata, 32'h2);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        bus(TXD, 32'hC3, 1);
        @(negedge clk);
        n = cyc;
        bus(32'h0, 0, 0);
        repeat (44) @(negedge clk);
        check_frame(n + 1, 8'hC3, "fC3");
        chk("fC3 idle after", {31'd0, busy_log[(n + 41) % 4096]}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
